// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter core between NUM_REQ on-chip producers.
// A round-robin arbiter picks one pending requester while the arbiter is idle
// and the core is free. The winner's word is captured into tx_data and the
// core's start handshake is run: a one-cycle write strobe, release of the
// strobe, then a wait for the frame to finish. tx_data is held constant from
// the strobe until the core drops tx_busy, because the core samples the word
// only at its start bit.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   req_valid    per-requester request, held with its data until req_ready
//   req_data     packed request words, requester i at [i*DATA_W +: DATA_W]
//   req_ready    one-hot, one-cycle accept pulse to the granted requester
//   tx_data      word driven to the UART core
//   tx_wr_en     one-cycle write strobe to the UART core
//   tx_busy      UART core busy indication
//   grant_id     index of the current (or last) granted requester
//   active       high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse when the core never acknowledged a strobe
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 16,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_wr_en,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STROBE  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]         state;
    logic [ID_W-1:0]    last_q;       // last granted requester; search starts after it
    logic [CNT_W-1:0]   timeout_cnt;  // RELEASE cycles spent waiting for tx_busy

    logic               grant_hit;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [DATA_W-1:0]  grant_word;

    // Round-robin search: last+1, last+2, ... wrapping modulo NUM_REQ.
    // The first asserted request in that order wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_hit = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_idx = ID_W'((int'(last_q) + off) % NUM_REQ);
            if (!grant_hit && req_valid[cand_idx]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Decode the winner into its ready bit and its data slice.
    always_comb begin
        grant_onehot = '0;
        grant_word   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_onehot[i] = 1'b1;
                grant_word      = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // req_ready, tx_wr_en and timeout_err are single-cycle pulses: they
    // default low every cycle and are raised only on the edge that
    // starts the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
            timeout_cnt <= '0;
            req_ready   <= '0;
            tx_data     <= '0;
            tx_wr_en    <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of the
            // order of statements in this block.
            req_ready   <= '0;
            tx_wr_en    <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // The core may be in use by another master; do not
                    // grant until it is free.
                    if (grant_hit && !tx_busy) begin
                        tx_data   <= grant_word;
                        grant_id  <= grant_idx;
                        last_q    <= grant_idx;
                        req_ready <= grant_onehot;
                        tx_wr_en  <= 1'b1;  // strobe coincides with req_ready
                        state     <= ST_STROBE;
                    end
                end

                ST_STROBE: begin
                    timeout_cnt <= '0;
                    state       <= ST_RELEASE;
                end

                ST_RELEASE: begin
                    if (tx_busy) begin
                        state <= ST_DRAIN;
                    end else if (timeout_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        // Core never started: drop the word, no retry.
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Requester drivers push the word
// they present into a per-requester queue; a monitor pops and compares on
// every req_ready pulse, predicting the winner from the round-robin rule
// applied to the request vector seen at the grant edge. A behavioural UART
// core model raises busy after each strobe and checks that tx_data holds.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int TMO     = 16;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_wr_en;
    logic                      tx_busy;
    logic [1:0]                grant_id;
    logic                      active;
    logic                      timeout_err;

    logic [DATA_W-1:0] word [NUM_REQ];
    logic              core_busy;
    logic              ext_busy;
    logic              core_en;
    logic              busy_rand;
    int                busy_len_cfg;

    int checks;
    int errors;

    logic [DATA_W-1:0] exp_q [NUM_REQ][$];
    int                grants_q [$];
    int                pulses [NUM_REQ];
    logic [NUM_REQ-1:0] valid_at_edge;
    int                model_last;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .START_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_wr_en   (tx_wr_en),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = core_busy | ext_busy;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = word[i];
    end

    // Request vector as the DUT sees it at each rising edge.
    always @(posedge clk) valid_at_edge <= req_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] bit_of(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    // Reference round-robin choice: first set bit after 'last', wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        int j;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (last + k) % NUM_REQ;
            if ((v & bit_of(j)) != '0) return j;
        end
        return -1;
    endfunction

    // Present one word from requester i and hold it until accepted.
    // Called at a falling edge.
    task automatic request(input int i, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        exp_q[i].push_back(d);
        word[i]   = d;
        req_valid = req_valid | bit_of(i);
        while (n < 400) begin
            @(negedge clk);
            n++;
            if ((req_ready & bit_of(i)) != '0) break;
        end
        if (n >= 400) check("req_ready_wait", 32'(i), 32'hFFFF_FFFF);
        req_valid = req_valid & ~bit_of(i);
    endtask

    task automatic driver(input int i, input int count, input int max_gap);
        for (int r = 0; r < count; r++) begin
            request(i, DATA_W'($urandom));
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((active !== 1'b0 || tx_busy !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < 500), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_order(input string name, input int first_after, input int len);
        check({name, "_count"}, 32'(grants_q.size()), 32'(len));
        for (int k = 0; k < len && k < grants_q.size(); k++)
            check(name, 32'(grants_q[k]), 32'((first_after + 1 + k) % NUM_REQ));
    endtask

    // UART core model: busy rises two cycles after the strobe and stays up
    // for the frame; tx_data must not move from the strobe until busy falls.
    initial begin
        logic [DATA_W-1:0] cap;
        logic              abort;
        int                len;
        core_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx_wr_en === 1'b1 && core_en) begin
                cap   = tx_data;
                abort = 1'b0;
                len   = busy_rand ? int'($urandom_range(3, 20)) : busy_len_cfg;
                repeat (2) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    else if (!abort) check("tx_data_hold", 32'(tx_data), 32'(cap));
                end
                core_busy = 1'b1;
                repeat (len) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    else if (!abort) check("tx_data_hold", 32'(tx_data), 32'(cap));
                end
                core_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        int w;
        int exp_w;
        model_last = NUM_REQ - 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_last = NUM_REQ - 1;
                continue;
            end
            check("strobe_with_ready", 32'(tx_wr_en), 32'(req_ready != '0));
            if (req_ready != '0) begin
                w = -1;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready == bit_of(i)) w = i;
                check("ready_onehot", 32'(w >= 0), 32'd1);
                if (w >= 0) begin
                    exp_w = rr_pick(valid_at_edge, model_last);
                    check("rr_winner", 32'(w), 32'(exp_w));
                    check("grant_id", 32'(grant_id), 32'(w));
                    if (exp_q[w].size() == 0) check("unexpected_grant", 32'(w), 32'hFFFF_FFFF);
                    else check("grant_data", 32'(tx_data), 32'(exp_q[w].pop_front()));
                    pulses[w]++;
                    grants_q.push_back(w);
                    model_last = w;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p2, n;
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = '0; ext_busy = 1'b0; core_en = 1'b1;
        busy_rand = 1'b0; busy_len_cfg = 40;
        for (int i = 0; i < NUM_REQ; i++) begin word[i] = '0; pulses[i] = 0; end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 2.
        request(2, 16'h00A5);
        check("single_grant_id", 32'(grant_id), 32'd2);
        check("single_active", 32'(active), 32'd1);
        check("single_tx_data", 32'(tx_data), 32'h00A5);
        wait_idle();
        check("single_pulses", 32'(pulses[2]), 32'd1);

        // Round robin with all four held: 8 frames.
        grants_q.delete();
        fork
            driver(0, 2, 0);
            driver(1, 2, 0);
            driver(2, 2, 0);
            driver(3, 2, 0);
        join
        wait_idle();
        check_order("rr_order", 2, 8);

        // Skip pattern: only 1 and 3, last grant = 1.
        request(1, DATA_W'($urandom));
        wait_idle();
        grants_q.delete();
        p0 = pulses[0]; p2 = pulses[2];
        fork
            driver(1, 2, 0);
            driver(3, 2, 0);
        join
        wait_idle();
        check("skip_count", 32'(grants_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < grants_q.size(); k++)
            check("skip_order", 32'(grants_q[k]), (k % 2 == 0) ? 32'd3 : 32'd1);
        check("skip_no_pulse0", 32'(pulses[0]), 32'(p0));
        check("skip_no_pulse2", 32'(pulses[2]), 32'(p2));

        // Core busy at request time: held off until busy drops.
        ext_busy = 1'b1;
        p0 = pulses[0];
        fork
            request(0, 16'hBEEF);
            begin
                repeat (10) @(negedge clk);
                check("busy_no_grant", 32'(pulses[0]), 32'(p0));
                check("busy_not_active", 32'(active), 32'd0);
                ext_busy = 1'b0;
                @(negedge clk);
                check("busy_first_free_grant", 32'(req_ready), 32'(bit_of(0)));
            end
        join
        wait_idle();

        // Start timeout: core never answers the strobe.
        core_en = 1'b0;
        grants_q.delete();
        fork
            request(1, 16'h5A5A);
            begin
                n = 0;
                while (tx_wr_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
                check("tmo_strobe_seen", 32'(n < 50), 32'd1);
                for (int k = 1; k <= 18; k++) begin
                    @(negedge clk);
                    if (k < 17) check("tmo_early", 32'(timeout_err), 32'd0);
                    if (k == 17) begin
                        check("tmo_pulse", 32'(timeout_err), 32'd1);
                        check("tmo_idle", 32'(active), 32'd0);
                        core_en = 1'b1;
                    end
                    if (k == 18) begin
                        check("tmo_single_pulse", 32'(timeout_err), 32'd0);
                        check("tmo_next_grant", 32'(req_ready), 32'(bit_of(2)));
                    end
                end
            end
            begin
                repeat (3) @(negedge clk);
                request(2, 16'hC3C3);
            end
        join
        wait_idle();
        check("tmo_no_retry", 32'(grants_q.size()), 32'd2);

        // Randomized traffic.
        busy_rand = 1'b1;
        fork
            driver(0, 6, 5);
            driver(1, 6, 5);
            driver(2, 6, 5);
            driver(3, 6, 5);
        join
        wait_idle();
        busy_rand = 1'b0;

        // Reset in the middle of DRAIN.
        busy_len_cfg = 40;
        request(1, 16'h1234);
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("drain_active", 32'(active), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle();
        grants_q.delete();
        fork
            request(2, 16'h2222);
            request(0, 16'h0000);
        join
        wait_idle();
        check("post_rst_count", 32'(grants_q.size()), 32'd2);
        if (grants_q.size() == 2) begin
            check("post_rst_first", 32'(grants_q[0]), 32'd0);
            check("post_rst_second", 32'(grants_q[1]), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core between NUM_REQ requesters using round-robin arbitration.
- Captures the granted word and sequences the core's start handshake: a one-cycle write strobe, then release, then wait for the frame to complete.
- Holds the data stable for the whole frame, because the core samples data only at the start bit.
- Sits between on-chip producers (bus bridge, debug logger, and so on) and the UART TX core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, width of the data word driven to the core
- START_TIMEOUT, 1024, max cycles to wait for core busy to rise after the strobe before aborting

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester request; held with data until its req_ready pulse
- req_data  in  NUM_REQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- tx_data  out  DATA_W  word driven to the core
- tx_wr_en  out  1  write strobe to the core
- tx_busy  in  1  core busy indication
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester
- active  out  1  high while any state other than IDLE
- timeout_err  out  1  one-cycle pulse when the start timeout expires

Behaviour:
- Reset:
  - rst is asynchronous and active-high; clock is clk.
  - On reset: state=IDLE, req_ready=0, tx_wr_en=0, tx_data=0, grant_id=0, active=0, timeout_err=0.
  - Last-grant pointer resets to NUM_REQ-1, so requester 0 wins first.
- Arbitration:
  - Search order is last+1, last+2, ... modulo NUM_REQ; the first asserted req_valid wins.
  - Arbitration happens only in IDLE.
  - A requester that drops valid before being granted is simply not seen.
- Core handshake (decided contract):
  - The core starts on a cycle with tx_wr_en=1.
  - It requires tx_wr_en to return low before it transmits.
  - It raises tx_busy within a few cycles of the strobe.
  - It keeps tx_busy high until the stop bit(s) complete.
  - tx_data must stay constant from the strobe until tx_busy falls.
- States:
  - IDLE: if any req_valid and tx_busy=0, then at the edge:
    - register the winner's data into tx_data;
    - set grant_id and the last-grant pointer;
    - pulse req_ready[winner] for exactly the next cycle;
    - go to STROBE.
    - If tx_busy=1 (core used by another master), stay in IDLE.
  - STROBE: tx_wr_en=1 for exactly one cycle; go to RELEASE. Clear the timeout counter.
  - RELEASE: tx_wr_en=0.
    - If tx_busy=1, go to DRAIN.
    - Otherwise increment the counter.
    - When the counter reaches START_TIMEOUT-1, pulse timeout_err and go to IDLE. The word is dropped and not retried.
  - DRAIN: wait for tx_busy=0, then go to IDLE.
- Latency: valid seen at edge t → req_ready high in cycle t+1 → tx_wr_en high in cycle t+1 (same cycle as req_ready).
- Back-to-back: the next grant may occur in the first IDLE cycle after tx_busy falls. There are no dead cycles beyond the IDLE evaluation.
- Sampling: tx_data changes only on a grant edge; it is unchanged in STROBE, RELEASE and DRAIN.
- Simultaneous events:
  - A new req_valid arriving while not in IDLE is held off; there is no loss provided the requester keeps it asserted.
  - A winner's valid falling in the same cycle it is granted is ignored, because the data was already captured.
- Reset mid-frame: all outputs go immediately to their reset values and tx_wr_en falls. Resetting the core is the integrator's responsibility.
- active = (state != IDLE).

Test Plan:
- Single request: req_valid[2]=1 with data 0x00A5, core model asserting busy 2 cycles after the strobe for 40 cycles → req_ready[2] high exactly 1 cycle; tx_wr_en high 1 cycle coincident with it; tx_data=0x00A5 stable until busy falls; grant_id=2.
- Round-robin fairness: all 4 valid held continuously for 8 frames → grant order 0,1,2,3,0,1,2,3; each req_ready pulses once per grant.
- Skip pattern: valid on 1 and 3 only, last=1 → next grant 3, then 1; requesters 0 and 2 never pulsed.
- Core busy at request time: tx_busy=1 externally with req_valid[0] → no grant, no strobe until busy=0; grant occurs in the first cycle busy=0.
- Timeout: core model never raises busy, START_TIMEOUT=16 → timeout_err pulses once exactly 16 cycles after entering RELEASE; state returns to IDLE; the next pending request is granted.
- Reset mid-DRAIN: assert rst while busy=1 and data=0x1234 → tx_data=0, active=0, req_ready=0 asynchronously; after release, requester 0 wins first.
